// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder over a word array with programmable wait states
//   clk, reset                   : clock and synchronous active-high reset
//   req_valid/req_ready          : request handshake (ready only in IDLE)
//   req_write/addr/wdata/be      : store flag, byte address, store data, byte lane enables
//   rsp_valid/rsp_ready          : response handshake, response held until taken
//   rsp_rdata/rsp_err            : load data (0 for stores/errors) and address-check error
//   MEM_ERR_CHECK_EN             : when defined, misaligned or out-of-range addresses are flagged and suppressed
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] CNT_INIT = 8'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] mem [DEPTH];
  logic          commit, c_wr, c_err;
  logic [31:0]   c_addr, c_wdata, c_word, merged;
  logic [3:0]    c_be;
  logic [AW-1:0] c_idx;
  // With zero wait states the commit edge is the accept edge, so operands come straight from the request.
  assign c_wr    = state_q == IDLE ? req_write : wr_q;
  assign c_addr  = state_q == IDLE ? req_addr  : addr_q;
  assign c_wdata = state_q == IDLE ? req_wdata : wdata_q;
  assign c_be    = state_q == IDLE ? req_be    : be_q;
  assign c_idx   = c_addr[AW+1:2];
  assign c_word  = mem[c_idx];
  assign commit  = (state_q == WAIT && cnt_q == 8'd0) ||
                   (state_q == IDLE && req_valid && WAIT_STATES == 0);
`ifdef MEM_ERR_CHECK_EN
  assign c_err = (|c_addr[1:0]) || (|c_addr[31:AW+2]);
`else
  wire unused_addr_bits = ^{c_addr[31:AW+2], c_addr[1:0]};
  assign c_err = 1'b0;
`endif
  always_comb begin
    merged = c_word;
    for (int i = 0; i < 4; i++)
      if (c_be[i]) merged[8*i +: 8] = c_wdata[8*i +: 8];
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        wr_d    = req_write;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        be_d    = req_be;
        cnt_d   = CNT_INIT;
        state_d = WAIT_STATES == 0 ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q == 8'd0 ? 8'd0 : cnt_q - 8'd1;
        state_d = cnt_q == 8'd0 ? RESP : WAIT;
      end
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    if (commit) begin
      rdata_d = (c_wr || c_err) ? 32'd0 : c_word;
      err_d   = c_err;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // Array is deliberately outside reset; a pending store is dropped if reset is sampled at its commit edge.
  always_ff @(posedge clk)
    if (!reset && commit && c_wr && !c_err) mem[c_idx] <= merged;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder (2 and 0 wait states)
module tb_data_mem_responder;
  logic clk = 0, reset = 1;
  logic        req_valid = 0, req_write = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_be = 0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        b_req_valid = 0, b_req_write = 0, b_rsp_ready = 0;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0;
  logic [3:0]  b_req_be = 0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  data_mem_responder #(.DEPTH(64), .WAIT_STATES(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));
  data_mem_responder #(.DEPTH(64), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask
  // One transaction on the 2-wait-state responder; hold = cycles to keep rsp_ready low in RESP.
  task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err, input int hold);
    int n;
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 0; req_write = 0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ".latency"}, 32'(n), 32'd3);
    check({tag, ".rdata"}, rsp_rdata, exp_rd);
    check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    check({tag, ".done_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", 32'(rsp_err), 32'd0);
    reset = 0;
    txn("st8", 1, 32'h8, 32'hDEADBEEF, 4'hF, 32'd0, 0, 0);
    txn("ld8", 0, 32'h8, 32'd0, 4'h0, 32'hDEADBEEF, 0, 0);
    txn("st8_be5", 1, 32'h8, 32'h11223344, 4'b0101, 32'd0, 0, 0);
    txn("ld8_mix", 0, 32'h8, 32'd0, 4'h0, 32'hDE22BE44, 0, 0);
    txn("st8_be0", 1, 32'h8, 32'h99999999, 4'h0, 32'd0, 0, 0);
    txn("ld8_hold", 0, 32'h8, 32'd0, 4'h3, 32'hDE22BE44, 0, 5);
    txn("st0", 1, 32'h0, 32'h12345678, 4'hF, 32'd0, 0, 0);
    txn("st4", 1, 32'h4, 32'hCAFEF00D, 4'hF, 32'd0, 0, 0);
`ifdef MEM_ERR_CHECK_EN
    txn("ld6_err", 0, 32'h6, 32'd0, 4'hF, 32'd0, 1, 0);
    txn("st100_err", 1, 32'h100, 32'h1, 4'hF, 32'd0, 1, 0);
    txn("ld0_kept", 0, 32'h0, 32'd0, 4'hF, 32'h12345678, 0, 0);
    txn("ld4_kept", 0, 32'h4, 32'd0, 4'hF, 32'hCAFEF00D, 0, 0);
`else
    txn("ld6_wrap", 0, 32'h6, 32'd0, 4'hF, 32'hCAFEF00D, 0, 0);
    txn("st100_alias", 1, 32'h100, 32'h1, 4'hF, 32'd0, 0, 0);
    txn("ld0_alias", 0, 32'h0, 32'd0, 4'hF, 32'h1, 0, 0);
`endif
    txn("st10", 1, 32'h10, 32'h01020304, 4'hF, 32'd0, 0, 0);
    txn("ld10", 0, 32'h10, 32'd0, 4'hF, 32'h01020304, 0, 0);
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 32'h10; req_wdata = 32'hAAAA5555; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 0;
    check("abort.in_wait", 32'(req_ready), 32'd0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("abort.req_ready", 32'(req_ready), 32'd1);
    check("abort.rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort.rsp_rdata", rsp_rdata, 32'd0);
    check("abort.rsp_err", 32'(rsp_err), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort.idle_valid", 32'(rsp_valid), 32'd0);
    end
    txn("ld10_old", 0, 32'h10, 32'd0, 4'hF, 32'h01020304, 0, 0);
    @(negedge clk);
    b_req_valid = 1; b_req_write = 1; b_req_addr = 32'hC; b_req_wdata = 32'h5A5A1234; b_req_be = 4'hF;
    b_rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("ws0.valid%0d", i), 32'(b_rsp_valid), 32'(i % 2 == 0));
      check($sformatf("ws0.ready%0d", i), 32'(b_req_ready), 32'(i % 2 == 1));
    end
    b_req_write = 0;
    @(posedge clk); #1;
    check("ws0.ld_valid", 32'(b_rsp_valid), 32'd1);
    check("ws0.ld_rdata", b_rsp_rdata, 32'h5A5A1234);
    check("ws0.ld_err", 32'(b_rsp_err), 32'd0);
    b_req_valid = 0;
    @(posedge clk); #1;
    check("ws0.idle_ready", 32'(b_req_ready), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
